// File: rtl/cmem_responder.sv
// cmem_responder: word-addressed memory responder with a one-entry
// last-read buffer. Reads that hit the buffered word complete in one cycle;
// read misses and all writes complete LATENCY cycles after the request.
//
// Ports
//   clk              sole clock, rising edge
//   rst_n            asynchronous active-low reset
//   mem_read         read request (level, held until mem_resp)
//   mem_write        write request (level, held until mem_resp; wins over read)
//   mem_byte_enable  byte lanes written on a write
//   mem_address      byte address, bits [1:0] ignored, wraps modulo DEPTH_WORDS
//   mem_wdata        write data
//   mem_resp         one-cycle completion pulse
//   mem_rdata        read data, held until the next read completion
//   hit              read was served from the last-read buffer
//
// state | meaning
// IDLE  | waiting for a request, latches it on the sampling edge
// BUSY  | miss latency count-down
// RESP  | completion cycle, commits on the edge leaving it

module cmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [3:0]  mem_byte_enable,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_wdata,
    output logic        mem_resp,
    output logic [31:0] mem_rdata,
    output logic        hit
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t          state;
    logic [3:0]      count;
    logic [AW-1:0]   idx_q;
    logic [AW-1:0]   buf_idx;
    logic            buf_valid;
    logic            op_write;
    logic            hit_q;
    logic [3:0]      be_q;
    logic [31:0]     wdata_q;
    logic [31:0]     rdata_hold;
    logic [31:0]     mem_q;
    logic [31:0]     mem [DEPTH_WORDS];

    logic            request;
    logic [AW-1:0]   req_idx;
    logic            commit;
    logic            commit_write;
    logic            unused_addr;

    assign request      = mem_read | mem_write;
    assign req_idx      = mem_address[AW+1:2];
    assign unused_addr  = ^{mem_address[31:AW+2], mem_address[1:0]};

    // Dropping the request in the RESP cycle cancels the completion, so the
    // pulse is qualified by the live request.
    assign commit       = (state == RESP) && request;
    assign commit_write = commit && op_write;

    assign mem_resp  = commit;
    assign hit       = commit && hit_q;
    // On a hit the buffered word is exactly the last read data, which any
    // write to that word would have invalidated.
    assign mem_rdata = (commit && !op_write && !hit_q) ? mem_q : rdata_hold;

    // Single-port store: written on the commit edge, otherwise read at the
    // latched index so the word is ready when RESP is entered from BUSY.
    always_ff @(posedge clk) begin
        if (commit_write) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end else begin
            mem_q <= mem[idx_q];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            count      <= '0;
            idx_q      <= '0;
            buf_idx    <= '0;
            buf_valid  <= 1'b0;
            op_write   <= 1'b0;
            hit_q      <= 1'b0;
            be_q       <= '0;
            wdata_q    <= '0;
            rdata_hold <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (request) begin
                        idx_q    <= req_idx;
                        be_q     <= mem_byte_enable;
                        wdata_q  <= mem_wdata;
                        op_write <= mem_write;
                        if (!mem_write && buf_valid && (buf_idx == req_idx)) begin
                            state <= RESP;
                            hit_q <= 1'b1;
                            count <= '0;
                        end else begin
                            state <= BUSY;
                            hit_q <= 1'b0;
                            count <= 4'(LATENCY - 1);
                        end
                    end
                end
                BUSY: begin
                    if (!request) begin
                        state <= IDLE;
                        count <= '0;
                    end else if (count == 4'd1) begin
                        state <= RESP;
                        count <= '0;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    if (request) begin
                        if (op_write) begin
                            if (buf_valid && (buf_idx == idx_q)) begin
                                buf_valid <= 1'b0;
                            end
                        end else begin
                            buf_idx    <= idx_q;
                            buf_valid  <= 1'b1;
                            rdata_hold <= hit_q ? rdata_hold : mem_q;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    count <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmem_responder.sv
module tb_cmem_responder;

    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic        clk;
    logic        rst_n;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic        mem_resp;
    logic [31:0] mem_rdata;
    logic        hit;

    cmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byte_enable (mem_byte_enable),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_resp        (mem_resp),
        .mem_rdata       (mem_rdata),
        .hit             (hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          cyc;
        bit          rd;
        logic [31:0] data;
        bit          hit;
    } exp_t;

    exp_t q[$];

    // Reference model: word array plus last-read buffer.
    logic [31:0] model_mem [DEPTH];
    bit          m_valid = 1'b0;
    int          m_idx   = 0;
    logic [31:0] exp_hold = 32'h0;

    // Monitor: compares every completion against the scoreboard, and checks
    // idle outputs in every other cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_resp) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_resp: cycle %0d got mem_resp=1, required no response", cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (cyc != e.cyc) begin
                        errors++;
                        $display("FAIL resp_cycle: got cycle %0d, required %0d", cyc, e.cyc);
                    end
                    checks++;
                    if (hit !== e.hit) begin
                        errors++;
                        $display("FAIL hit: cycle %0d got %0b, required %0b", cyc, hit, e.hit);
                    end
                    if (e.rd) begin
                        checks++;
                        if (mem_rdata !== e.data) begin
                            errors++;
                            $display("FAIL rdata: cycle %0d got %08h, required %08h", cyc, mem_rdata, e.data);
                        end
                        exp_hold = e.data;
                    end
                end
            end else begin
                checks++;
                if (hit !== 1'b0 || mem_rdata !== exp_hold) begin
                    errors++;
                    $display("FAIL idle_outputs: cycle %0d got hit=%0b rdata=%08h, required hit=0 rdata=%08h",
                             cyc, hit, mem_rdata, exp_hold);
                end
            end
        end
    end

    task automatic drop_req();
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            drop_req();
        end
    endtask

    // Issue one request; abort drops it inside the BUSY/RESP window.
    task automatic issue(input bit rd, input bit wr, input logic [31:0] a,
                         input logic [3:0] b, input logic [31:0] d, input bit abort);
        int  idx;
        bit  h;
        int  lat;
        int  c;
        int  k;
        bit  seen;
        exp_t e;
        idx = int'((a >> 2) % DEPTH);
        h   = !wr && rd && m_valid && (m_idx == idx);
        lat = h ? 1 : LAT;
        @(posedge clk); #1;
        mem_read        = rd;
        mem_write       = wr;
        mem_address     = a;
        mem_byte_enable = b;
        mem_wdata       = d;
        c = cyc;
        if (abort) begin
            k = $urandom_range(1, lat);
            repeat (k) @(posedge clk);
            #1;
            drop_req();
            mem_address = $urandom;
            mem_wdata   = $urandom;
        end else begin
            e.cyc  = c + lat;
            e.rd   = !wr;
            e.data = model_mem[idx];
            e.hit  = h;
            q.push_back(e);
            if (wr) begin
                for (int i = 0; i < 4; i++)
                    if (b[i]) model_mem[idx][8*i +: 8] = d[8*i +: 8];
                if (m_valid && m_idx == idx) m_valid = 1'b0;
            end else begin
                m_valid = 1'b1;
                m_idx   = idx;
            end
            // Latched values must win over changes during the wait.
            if (lat > 1) begin
                @(posedge clk); #1;
                mem_address     = $urandom;
                mem_wdata       = $urandom;
                mem_byte_enable = 4'($urandom);
            end
            seen = 1'b0;
            for (int i = 0; i < 40 && !seen; i++) begin
                @(negedge clk);
                if (mem_resp) seen = 1'b1;
            end
            if (!seen) begin
                checks++;
                errors++;
                $display("FAIL resp_timeout: no mem_resp within 40 cycles of cycle %0d, required one", c);
                if (q.size() > 0) void'(q.pop_front());
            end
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (mem_resp !== 1'b0 || hit !== 1'b0 || mem_rdata !== 32'h0) begin
            errors++;
            $display("FAIL %s: got resp=%0b hit=%0b rdata=%08h, required 0 0 00000000",
                     name, mem_resp, hit, mem_rdata);
        end
    endtask

    task automatic reset_mid_busy(input logic [31:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        mem_write       = 1'b1;
        mem_address     = a;
        mem_byte_enable = 4'hF;
        mem_wdata       = d;
        @(posedge clk); #1;
        rst_n = 1'b0;
        drop_req();
        #2;
        check_reset_outputs("reset_mid_busy");
        m_valid  = 1'b0;
        exp_hold = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [31:0] a;
    int          w;

    initial begin
        rst_n           = 1'b0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_byte_enable = 4'h0;
        mem_address     = 32'h0;
        mem_wdata       = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_state");
        @(negedge clk);
        rst_n = 1'b1;

        // Known contents for every word the bench will read.
        for (int i = 0; i < 32; i++)
            issue(1'b0, 1'b1, 32'(i * 4), 4'hF, $urandom, 1'b0);
        issue(1'b0, 1'b1, 32'h100, 4'hF, $urandom, 1'b0);

        // Write, miss read, hit read.
        issue(1'b0, 1'b1, 32'h100, 4'hF, 32'hDEADBEEF, 1'b0);
        idle(1);
        issue(1'b1, 1'b0, 32'h100, 4'h0, 32'h0, 1'b0);
        idle(1);
        issue(1'b1, 1'b0, 32'h100, 4'h0, 32'h0, 1'b0);
        idle(2);

        // Partial write invalidates the buffered word.
        issue(1'b0, 1'b1, 32'h40, 4'hF, 32'h11223344, 1'b0);
        issue(1'b1, 1'b0, 32'h40, 4'h0, 32'h0, 1'b0);
        issue(1'b0, 1'b1, 32'h40, 4'b0101, 32'hAABBCCDD, 1'b0);
        issue(1'b1, 1'b0, 32'h40, 4'h0, 32'h0, 1'b0);
        idle(1);

        // Zero byte enable completes without changing data.
        issue(1'b0, 1'b1, 32'h40, 4'h0, 32'hFFFFFFFF, 1'b0);
        issue(1'b1, 1'b0, 32'h40, 4'h0, 32'h0, 1'b0);
        idle(1);

        // Back-to-back reads with mem_read held high.
        issue(1'b0, 1'b1, 32'h8, 4'hF, 32'h01020304, 1'b0);
        idle(1);
        issue(1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
        issue(1'b1, 1'b0, 32'h4, 4'h0, 32'h0, 1'b0);
        issue(1'b1, 1'b0, 32'h4, 4'h0, 32'h0, 1'b0);
        idle(1);

        // Address wrap.
        issue(1'b0, 1'b1, 32'h1000, 4'hF, 32'h5, 1'b0);
        issue(1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
        issue(1'b1, 1'b0, 32'h3, 4'h0, 32'h0, 1'b0);
        idle(1);

        // Dropped write, then read shows old data.
        issue(1'b0, 1'b1, 32'h10, 4'hF, 32'hCAFEF00D, 1'b1);
        issue(1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 1'b0);
        idle(1);

        // Reset during BUSY, then confirm the write was discarded.
        reset_mid_busy(32'h14, 32'hBAD0BAD0);
        idle(2);
        issue(1'b1, 1'b0, 32'h14, 4'h0, 32'h0, 1'b0);
        idle(1);

        // Read and write both high is a write.
        issue(1'b1, 1'b1, 32'h18, 4'hF, 32'h7, 1'b0);
        issue(1'b1, 1'b0, 32'h18, 4'h0, 32'h0, 1'b0);
        idle(1);

        // Aborted hit in its RESP cycle leaves the buffer and rdata alone.
        issue(1'b1, 1'b0, 32'h18, 4'h0, 32'h0, 1'b1);
        issue(1'b1, 1'b0, 32'h18, 4'h0, 32'h0, 1'b0);
        idle(1);

        // Randomized traffic over a small word set so hits are frequent.
        for (int n = 0; n < 400; n++) begin
            w = $urandom_range(0, 7);
            a = ($urandom & 32'hFFFF_F000) | 32'(w * 4) | 32'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0, 1, 2: issue(1'b1, 1'b0, a, 4'($urandom), $urandom, ($urandom_range(0, 7) == 0));
                3, 4:    issue(1'b0, 1'b1, a, 4'($urandom), $urandom, ($urandom_range(0, 7) == 0));
                default: issue(1'b1, 1'b1, a, 4'($urandom), $urandom, ($urandom_range(0, 7) == 0));
            endcase
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        idle(3);

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d responses outstanding, required 0", q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
